multi_channel_pulse_width_detector: RTL and testbench

// - Per-channel detector for rising edges, falling edges and high pulses whose width falls in [MIN_W, MAX_W] cycles.
// - Replaces single-channel fixed 010 detection for status/strobe inputs that are already synchronous to clk.
// - Also reports the measured width of every completed pulse and flags runs that overrun MAX_W.
// - Defaults (N_CH=4, MIN_W=MAX_W=1) give exact one-cycle-pulse (010) detection on each channel.
//

---
 rtl/multi_channel_pulse_width_detector.sv | 86 ++++++++
 tb/tb_multi_channel_pulse_width_detector.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/multi_channel_pulse_width_detector.sv
// Per-channel edge, pulse-width and overrun detector for inputs that are already synchronous to clk.
// Define MULTI_CHANNEL_PULSE_WIDTH_DETECTOR_STICKY_EN to add sticky per-channel status flags cleared by clr.
module multi_channel_pulse_width_detector #(
   parameter int unsigned N_CH  = 4,
   parameter int unsigned CNT_W = 4,
   parameter int unsigned MIN_W = 1,
   parameter int unsigned MAX_W = 1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [N_CH-1:0]       a,
`ifdef MULTI_CHANNEL_PULSE_WIDTH_DETECTOR_STICKY_EN
   input  logic [N_CH-1:0]       clr,
   output logic [N_CH-1:0]       status,
`endif
   output logic [N_CH-1:0]       rise,
   output logic [N_CH-1:0]       fall,
   output logic [N_CH-1:0]       detected,
   output logic [N_CH-1:0]       overrun,
   output logic [N_CH*CNT_W-1:0] width
);

   if (!((MIN_W >= 1) && (MIN_W <= MAX_W) && (MAX_W <= (2 ** CNT_W) - 2))) begin : g_param_err
      $error("multi_channel_pulse_width_detector: need 1 <= MIN_W <= MAX_W <= 2**CNT_W-2");
   end

   localparam logic [CNT_W-1:0] CntSat = '1;
   localparam logic [CNT_W-1:0] MinW   = CNT_W'(MIN_W);
   localparam logic [CNT_W-1:0] MaxW   = CNT_W'(MAX_W);

   for (genvar i = 0; i < N_CH; i++) begin : g_ch
      logic             a_q;
      logic [CNT_W-1:0] cnt_q, cnt_d;
      logic [CNT_W-1:0] wid_q, wid_d;
      logic             rise_c, fall_c, det_c, ovr_c;

      always_comb begin
         rise_c = rst_n & a[i] & ~a_q;
         fall_c = rst_n & ~a[i] & a_q;
         det_c  = fall_c & (cnt_q >= MinW) & (cnt_q <= MaxW);
         ovr_c  = rst_n & a[i] & (cnt_q == MaxW);
         cnt_d  = '0;
         if (a[i]) begin
            cnt_d = (cnt_q == CntSat) ? cnt_q : cnt_q + 1'b1;
         end
         // Width is latched on every fall, accepted or not; saturation reads as "too long".
         wid_d = fall_c ? cnt_q : wid_q;
      end

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            a_q   <= 1'b0;
            cnt_q <= '0;
            wid_q <= '0;
         end else begin
            a_q   <= a[i];
            cnt_q <= cnt_d;
            wid_q <= wid_d;
         end
      end

      assign rise[i]                  = rise_c;
      assign fall[i]                  = fall_c;
      assign detected[i]              = det_c;
      assign overrun[i]               = ovr_c;
      assign width[i*CNT_W +: CNT_W]  = wid_q;

`ifdef MULTI_CHANNEL_PULSE_WIDTH_DETECTOR_STICKY_EN
      logic status_q;

      // Set has priority over clear so a detection coinciding with clr is never lost.
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            status_q <= 1'b0;
         end else if (det_c) begin
            status_q <= 1'b1;
         end else if (clr[i]) begin
            status_q <= 1'b0;
         end
      end

      assign status[i] = status_q;
`endif
   end

endmodule

// File: tb/tb_multi_channel_pulse_width_detector.sv
// Directed bench: default-parameter instance plus a CNT_W=3, MIN_W=2, MAX_W=3 instance.
module tb_multi_channel_pulse_width_detector;

   logic        clk;
   logic        rst_n;
   logic [3:0]  a0, b;
   logic [3:0]  rise0, fall0, det0, ovr0;
   logic [15:0] width0;
   logic [3:0]  rise1, fall1, det1, ovr1;
   logic [11:0] width1;
   logic [3:0]  clr0, clr1;
   logic [3:0]  status0, status1;

   int n_chk  = 0;
   int n_pass = 0;

   multi_channel_pulse_width_detector u_dut0 (
      .clk      (clk),
      .rst_n    (rst_n),
      .a        (a0),
`ifdef MULTI_CHANNEL_PULSE_WIDTH_DETECTOR_STICKY_EN
      .clr      (clr0),
      .status   (status0),
`endif
      .rise     (rise0),
      .fall     (fall0),
      .detected (det0),
      .overrun  (ovr0),
      .width    (width0)
   );

   multi_channel_pulse_width_detector #(
      .N_CH  (4),
      .CNT_W (3),
      .MIN_W (2),
      .MAX_W (3)
   ) u_dut1 (
      .clk      (clk),
      .rst_n    (rst_n),
      .a        (b),
`ifdef MULTI_CHANNEL_PULSE_WIDTH_DETECTOR_STICKY_EN
      .clr      (clr1),
      .status   (status1),
`endif
      .rise     (rise1),
      .fall     (fall1),
      .detected (det1),
      .overrun  (ovr1),
      .width    (width1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   // New input values take effect just after a rising edge; checks happen mid-cycle.
   task automatic drive(input logic [3:0] va, input logic [3:0] vb);
      @(posedge clk);
      #1;
      a0 = va;
      b  = vb;
      #3;
   endtask

   initial begin
      int ovr_cnt;
      rst_n = 1'b0;
      a0    = '0;
      b     = '0;
      clr0  = '0;
      clr1  = '0;

      // Outputs gated during reset even with inputs high.
      #2;
      a0 = 4'hF;
      b  = 4'hF;
      #1;
      chk("rst_rise_gated", rise0, 4'h0);
      chk("rst_ovr_gated", ovr0, 4'h0);
      chk("rst_width", width0, 16'h0);
      a0 = '0;
      b  = '0;
      @(posedge clk);
      @(posedge clk);
      #1 rst_n = 1'b1;

      drive(4'h0, 4'h0);
      chk("idle_det", det0, 4'h0);
      chk("idle_fall", fall0, 4'h0);

      // ch0 010 pulse
      drive(4'b0001, 4'h0);
      chk("p010_rise", rise0, 4'b0001);
      chk("p010_ovr", ovr0, 4'h0);
      drive(4'h0, 4'h0);
      chk("p010_fall", fall0, 4'b0001);
      chk("p010_det", det0, 4'b0001);
      drive(4'h0, 4'h0);
      chk("p010_det_once", det0, 4'h0);
      chk("p010_width", width0, 16'h0001);

      // ch1 0110 pulse: overrun, no detect
      drive(4'b0010, 4'h0);
      chk("p0110_rise", rise0, 4'b0010);
      drive(4'b0010, 4'h0);
      chk("p0110_ovr", ovr0, 4'b0010);
      drive(4'h0, 4'h0);
      chk("p0110_fall", fall0, 4'b0010);
      chk("p0110_det", det0, 4'h0);
      drive(4'h0, 4'h0);
      chk("p0110_width", width0, 16'h0021);

      // Simultaneous one-cycle pulses on ch0, ch2, ch3
      drive(4'b1101, 4'h0);
      drive(4'h0, 4'h0);
      chk("simul_det", det0, 4'b1101);
      drive(4'h0, 4'h0);
      chk("simul_width", width0, 16'h1121);

      // Back-to-back 1,0,1,0 on ch0
      drive(4'b0001, 4'h0);
      drive(4'h0, 4'h0);
      chk("b2b_det1", det0, 4'b0001);
      drive(4'b0001, 4'h0);
      chk("b2b_rise2", rise0, 4'b0001);
      drive(4'h0, 4'h0);
      chk("b2b_det2", det0, 4'b0001);

      // MIN_W=2, MAX_W=3 instance: pulses of 1..4 cycles on ch0
      drive(4'h0, 4'b0001);
      drive(4'h0, 4'h0);
      chk("w1_fall", fall1, 4'b0001);
      chk("w1_det", det1, 4'h0);
      drive(4'h0, 4'b0001);
      drive(4'h0, 4'b0001);
      drive(4'h0, 4'h0);
      chk("w2_det", det1, 4'b0001);
      drive(4'h0, 4'b0001);
      drive(4'h0, 4'b0001);
      drive(4'h0, 4'b0001);
      chk("w3_no_ovr", ovr1, 4'h0);
      drive(4'h0, 4'h0);
      chk("w3_det", det1, 4'b0001);
      drive(4'h0, 4'b0001);
      drive(4'h0, 4'b0001);
      drive(4'h0, 4'b0001);
      chk("w4_ovr_3rd", ovr1, 4'h0);
      drive(4'h0, 4'b0001);
      chk("w4_ovr_4th", ovr1, 4'b0001);
      drive(4'h0, 4'h0);
      chk("w4_det", det1, 4'h0);
      drive(4'h0, 4'h0);
      chk("w4_width", width1[2:0], 3'd4);

      // ch2 high 10 cycles: saturate at 7, single overrun
      ovr_cnt = 0;
      for (int i = 0; i < 10; i++) begin
         drive(4'h0, 4'b0100);
         if (ovr1[2]) ovr_cnt++;
      end
      chk("sat_ovr_count", ovr_cnt, 1);
      drive(4'h0, 4'h0);
      chk("sat_det", det1, 4'h0);
      drive(4'h0, 4'h0);
      chk("sat_width_ch2", width1[8:6], 3'd7);
      chk("sat_width_ch0", width1[2:0], 3'd4);

      // Reset mid-pulse discards the run
      drive(4'b0100, 4'h0);
      drive(4'b0100, 4'h0);
      chk("midrst_ovr", ovr0, 4'b0100);
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      a0    = 4'h0;
      #3;
      chk("midrst_fall", fall0, 4'h0);
      chk("midrst_width", width0, 16'h0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      #3;
      chk("midrst_rel_det", det0, 4'h0);
      drive(4'h0, 4'h0);
      chk("midrst_rel_width", width0, 16'h0);

      // High input at reset release: rise at once, then a 1-cycle pulse
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      a0    = 4'b0001;
      @(posedge clk);
      #1 rst_n = 1'b1;
      #3;
      chk("rel_high_rise", rise0, 4'b0001);
      drive(4'h0, 4'h0);
      chk("rel_high_det", det0, 4'b0001);
      drive(4'h0, 4'h0);
      chk("rel_high_width", width0, 16'h0001);

`ifdef MULTI_CHANNEL_PULSE_WIDTH_DETECTOR_STICKY_EN
      drive(4'b1000, 4'h0);
      drive(4'h0, 4'h0);
      chk("sticky_det", det0, 4'b1000);
      chk("sticky_not_yet", status0, 4'h0);
      drive(4'h0, 4'h0);
      chk("sticky_set", status0, 4'b1000);
      drive(4'h0, 4'h0);
      chk("sticky_hold", status0, 4'b1000);
      clr0 = 4'b1000;
      drive(4'h0, 4'h0);
      clr0 = 4'h0;
      chk("sticky_clr", status0, 4'h0);
      drive(4'b1000, 4'h0);
      drive(4'h0, 4'h0);
      clr0 = 4'b1000;
      chk("sticky_det2", det0, 4'b1000);
      drive(4'h0, 4'h0);
      clr0 = 4'h0;
      chk("sticky_set_wins", status0, 4'b1000);
      chk("sticky_dut1_idle", status1, 4'h0);
`endif

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
